cv32e40p_sleep_ctrl: RTL and testbench

//  Drives en_i of the core clock gate from a free-running clk_i.
//  - Tracks fetch-enable, WFI, pipeline busy, interrupt and debug requests.
//  - Gates the core clock only after a drained, idle pipeline.
//  - Re-enables the clock for a fixed warm-up period before reporting wake.
//  - Counts gated cycles for power statistics.

---
 rtl/cv32e40p_sleep_pkg.sv | 21 ++
 rtl/cv32e40p_sat_counter.sv | 35 +++
 rtl/cv32e40p_sleep_ctrl.sv | 108 ++++++++++
 tb/tb_cv32e40p_sleep_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_sleep_pkg.sv
// Shared types and helpers for the core sleep controller.
package cv32e40p_sleep_pkg;

  // Sleep controller states with a fixed encoding; unused codes recover to StBoot.
  typedef enum logic [2:0] {
    StBoot  = 3'd0,
    StRun   = 3'd1,
    StDrain = 3'd2,
    StSleep = 3'd3,
    StWake  = 3'd4
  } sleep_state_e;

  // Width needed by the idle/wake counters: enough to hold max(idle, wake) cycles.
  function automatic int unsigned cnt_w(input int unsigned idle_cycles,
                                        input int unsigned wake_cycles);
    int unsigned max_cycles;
    max_cycles = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/cv32e40p_sat_counter.sv
// Saturating up-counter with a clear that wins over increment.
module cv32e40p_sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  // Next count: clear first, otherwise increment until all-ones and hold there.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + Width'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cv32e40p_sleep_ctrl.sv
// Core clock-gate controller: drains the pipeline after WFI, gates the core clock,
// and runs a fixed warm-up period before handing the core back.
module cv32e40p_sleep_ctrl
  import cv32e40p_sleep_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned STAT_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fetch_enable_i,
  input  logic              wfi_req_i,
  input  logic              core_busy_i,
  input  logic              irq_pending_i,
  input  logic              debug_req_i,
  input  logic              clr_stats_i,
  output logic              clock_en_o,
  output logic              core_sleep_o,
  output logic              wake_ack_o,
  output logic [STAT_W-1:0] sleep_cycles_o
);

  localparam int unsigned      CntW     = cnt_w(IDLE_CYCLES, WAKE_CYCLES);
  localparam logic [CntW-1:0]  IdleLast = CntW'(IDLE_CYCLES - 1);
  localparam logic [CntW-1:0]  WakeLast = CntW'(WAKE_CYCLES - 1);

  sleep_state_e    state_q, state_d;
  logic [CntW-1:0] idle_cnt_q, idle_cnt_d;
  logic [CntW-1:0] wake_cnt_q, wake_cnt_d;
  logic            clock_en_q, core_sleep_q, wake_ack_q;
  logic            wake_src;

  assign wake_src = irq_pending_i | debug_req_i;

  // Next-state decode; counters only hold non-zero values inside their own state.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = '0;
    wake_cnt_d = '0;
    case (state_q)
      StBoot: begin
        if (fetch_enable_i) state_d = StWake;
      end
      StRun: begin
        // A wake source alongside WFI means the core would wake at once: skip sleeping.
        if (wfi_req_i && !wake_src) state_d = StDrain;
      end
      StDrain: begin
        // Abort beats sleep entry when both happen in the same cycle.
        if (wake_src) begin
          state_d = StRun;
        end else if (core_busy_i) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IdleLast) begin
          state_d = StSleep;
        end else begin
          idle_cnt_d = idle_cnt_q + CntW'(1);
        end
      end
      StSleep: begin
        if (wake_src) state_d = StWake;
      end
      StWake: begin
        if (wake_cnt_q == WakeLast) begin
          state_d = StRun;
        end else begin
          wake_cnt_d = wake_cnt_q + CntW'(1);
        end
      end
      default: state_d = StBoot;
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StBoot;
      idle_cnt_q   <= '0;
      wake_cnt_q   <= '0;
      clock_en_q   <= 1'b0;
      core_sleep_q <= 1'b1;
      wake_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      wake_cnt_q   <= wake_cnt_d;
      clock_en_q   <= (state_d == StRun) || (state_d == StDrain) || (state_d == StWake);
      core_sleep_q <= (state_d == StBoot) || (state_d == StSleep) || (state_d == StWake);
      wake_ack_q   <= (state_q == StWake) && (state_d == StRun);
    end
  end

  cv32e40p_sat_counter #(
    .Width (STAT_W)
  ) u_sleep_stats (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr_stats_i),
    .inc_i   (state_q == StSleep),
    .count_o (sleep_cycles_o)
  );

  assign clock_en_o   = clock_en_q;
  assign core_sleep_o = core_sleep_q;
  assign wake_ack_o   = wake_ack_q;

endmodule

// File: tb/tb_cv32e40p_sleep_ctrl.sv
// Directed bench for the sleep controller: a phase/timer model checked every cycle,
// plus literal expectations at the key cycles of each scenario.
module tb_cv32e40p_sleep_ctrl;

  localparam int unsigned IdleCycles = 4;
  localparam int unsigned WakeCycles = 2;

  localparam int PBoot  = 0;
  localparam int PRun   = 1;
  localparam int PDrain = 2;
  localparam int PSleep = 3;
  localparam int PWake  = 4;

  logic        clk;
  logic        rst, fe, wfi, busy, irq, dbg, clr;
  logic        clock_en, core_sleep, wake_ack;
  logic [31:0] stats;
  logic        clock_en2, core_sleep2, wake_ack2;
  logic [1:0]  stats2;

  int n_tests;
  int n_fail;
  int cyc;

  // Model state
  int     m_phase;
  int     m_streak;
  int     m_wake_left;
  logic   m_ack;
  longint m_s32;
  longint m_s2;

  cv32e40p_sleep_ctrl #(
    .IDLE_CYCLES (IdleCycles),
    .WAKE_CYCLES (WakeCycles),
    .STAT_W      (32)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .fetch_enable_i (fe),
    .wfi_req_i      (wfi),
    .core_busy_i    (busy),
    .irq_pending_i  (irq),
    .debug_req_i    (dbg),
    .clr_stats_i    (clr),
    .clock_en_o     (clock_en),
    .core_sleep_o   (core_sleep),
    .wake_ack_o     (wake_ack),
    .sleep_cycles_o (stats)
  );

  cv32e40p_sleep_ctrl #(
    .IDLE_CYCLES (IdleCycles),
    .WAKE_CYCLES (WakeCycles),
    .STAT_W      (2)
  ) dut2 (
    .clk_i          (clk),
    .rst_i          (rst),
    .fetch_enable_i (fe),
    .wfi_req_i      (wfi),
    .core_busy_i    (busy),
    .irq_pending_i  (irq),
    .debug_req_i    (dbg),
    .clr_stats_i    (clr),
    .clock_en_o     (clock_en2),
    .core_sleep_o   (core_sleep2),
    .wake_ack_o     (wake_ack2),
    .sleep_cycles_o (stats2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input int k);
    rst  = (k == 0) || (k == 80);
    fe   = (k >= 3 && k <= 8) || (k == 86);
    wfi  = (k == 10) || (k == 30) || (k == 50) || (k == 55) || (k == 70) || (k == 76) ||
           (k == 90);
    busy = (k == 32);
    irq  = (k == 40) || (k == 50) || (k == 58) || (k == 83) || (k == 94);
    dbg  = (k == 20) || (k == 22);
    clr  = (k == 45) || (k == 77);
  endtask

  // Advance the model by one clock edge using the inputs of the current cycle.
  task automatic model_step();
    logic src;
    src = irq | dbg;
    if (rst) begin
      m_phase     = PBoot;
      m_streak    = 0;
      m_wake_left = 0;
      m_ack       = 1'b0;
      m_s32       = 0;
      m_s2        = 0;
      return;
    end
    m_ack = 1'b0;
    if (clr) begin
      m_s32 = 0;
      m_s2  = 0;
    end else if (m_phase == PSleep) begin
      if (m_s32 < 64'hFFFF_FFFF) m_s32++;
      if (m_s2 < 3) m_s2++;
    end
    case (m_phase)
      PBoot: if (fe) begin
        m_phase     = PWake;
        m_wake_left = WakeCycles;
      end
      PRun: if (wfi && !src) begin
        m_phase  = PDrain;
        m_streak = 0;
      end
      PDrain: begin
        if (src) m_phase = PRun;
        else if (busy) m_streak = 0;
        else begin
          m_streak++;
          if (m_streak == IdleCycles) m_phase = PSleep;
        end
      end
      PSleep: if (src) begin
        m_phase     = PWake;
        m_wake_left = WakeCycles;
      end
      default: begin
        m_wake_left--;
        if (m_wake_left == 0) begin
          m_phase = PRun;
          m_ack   = 1'b1;
        end
      end
    endcase
  endtask

  task automatic compare_model();
    logic exp_en, exp_sl;
    exp_en = (m_phase == PRun) || (m_phase == PDrain) || (m_phase == PWake);
    exp_sl = (m_phase == PBoot) || (m_phase == PSleep) || (m_phase == PWake);
    check("clock_en", 64'(clock_en), 64'(exp_en));
    check("core_sleep", 64'(core_sleep), 64'(exp_sl));
    check("wake_ack", 64'(wake_ack), 64'(m_ack));
    check("sleep_cycles", 64'(stats), 64'(m_s32));
    check("clock_en_w2", 64'(clock_en2), 64'(exp_en));
    check("sleep_cycles_w2", 64'(stats2), 64'(m_s2));
  endtask

  // Hand-computed expectations that pin the model to the intended timing.
  task automatic pins(input int k);
    case (k)
      3:  check("pin_boot_gated", 64'(clock_en), 64'd0);
      4:  check("pin_fetch_clk_on", 64'(clock_en), 64'd1);
      5:  begin
        check("pin_no_early_ack", 64'(wake_ack), 64'd0);
        check("pin_warmup_sleep", 64'(core_sleep), 64'd1);
      end
      6:  begin
        check("pin_boot_ack", 64'(wake_ack), 64'd1);
        check("pin_boot_awake", 64'(core_sleep), 64'd0);
      end
      7:  check("pin_ack_pulse", 64'(wake_ack), 64'd0);
      14: check("pin_drain_clk", 64'(clock_en), 64'd1);
      15: begin
        check("pin_gate_at_15", 64'(clock_en), 64'd0);
        check("pin_sleep_at_15", 64'(core_sleep), 64'd1);
        check("pin_stats_15", 64'(stats), 64'd0);
      end
      16: check("pin_stats_16", 64'(stats), 64'd1);
      20: check("pin_stats_20", 64'(stats), 64'd5);
      21: begin
        check("pin_dbg_clk_on", 64'(clock_en), 64'd1);
        check("pin_stats_21", 64'(stats), 64'd6);
        check("pin_stats_sat", 64'(stats2), 64'd3);
      end
      22: check("pin_dbg_no_ack", 64'(wake_ack), 64'd0);
      23: begin
        check("pin_dbg_ack", 64'(wake_ack), 64'd1);
        check("pin_dbg_awake", 64'(core_sleep), 64'd0);
      end
      24: check("pin_stats_frozen", 64'(stats), 64'd6);
      35: check("pin_busy_not_15", 64'(clock_en), 64'd1);
      36: check("pin_busy_clk_36", 64'(clock_en), 64'd1);
      37: check("pin_busy_gate_37", 64'(clock_en), 64'd0);
      41: check("pin_stats_41", 64'(stats), 64'd10);
      46: check("pin_clr", 64'(stats), 64'd0);
      51: begin
        check("pin_wfi_irq_run", 64'(clock_en), 64'd1);
        check("pin_wfi_irq_awake", 64'(core_sleep), 64'd0);
      end
      59: begin
        check("pin_abort_clk", 64'(clock_en), 64'd1);
        check("pin_abort_no_ack", 64'(wake_ack), 64'd0);
      end
      78: check("pin_clr_wins", 64'(stats), 64'd0);
      79: check("pin_after_clr", 64'(stats), 64'd1);
      80: check("pin_sleep_80", 64'(clock_en), 64'd0);
      81: begin
        check("pin_rst_clk", 64'(clock_en), 64'd0);
        check("pin_rst_sleep", 64'(core_sleep), 64'd1);
        check("pin_rst_stats", 64'(stats), 64'd0);
      end
      84: check("pin_boot_irq_ign", 64'(clock_en), 64'd0);
      89: check("pin_reboot_ack", 64'(wake_ack), 64'd1);
      95: begin
        check("pin_abort_prio", 64'(clock_en), 64'd1);
        check("pin_abort_prio_sl", 64'(core_sleep), 64'd0);
      end
      default: ;
    endcase
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    drive(0);
    m_phase = PBoot;
    m_streak = 0;
    m_wake_left = 0;
    m_ack = 1'b0;
    m_s32 = 0;
    m_s2 = 0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 100; k++) begin
      cyc = k;
      drive(k);
      @(negedge clk);
      if (k > 0) begin
        compare_model();
        pins(k);
      end
      model_step();
      @(posedge clk);
      #1;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
